// File: rtl/pwm_cfg_arbiter_if.sv
// Register-write handshake bundle for the two PWM config requesters (A = SPI decoder, B = sequencer).
interface pwm_cfg_arbiter_if #(
   parameter int unsigned ADDR_W = 7,
   parameter int unsigned DATA_W = 8
);
   logic              a_valid;
   logic [ADDR_W-1:0] a_addr;
   logic [DATA_W-1:0] a_data;
   logic              a_ready;
   logic              b_valid;
   logic [ADDR_W-1:0] b_addr;
   logic [DATA_W-1:0] b_data;
   logic              b_ready;

   modport master (
      output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
      input  a_ready, b_ready
   );

   modport slave (
      input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
      output a_ready, b_ready
   );
endinterface

// File: rtl/pwm_cfg_arbiter.sv
// PWM configuration register bank: round-robin write arbitration into shadow registers,
// committed to the active outputs at PWM period boundaries.
module pwm_cfg_arbiter #(
   parameter int unsigned ADDR_W      = 7,
   parameter int unsigned DATA_W      = 8,
   parameter bit          SYNC_UPDATE = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   pwm_cfg_arbiter_if.slave  bus,
   input  logic              period_start,
   output logic [DATA_W-1:0] en_reg_out_7_0,
   output logic [DATA_W-1:0] en_reg_out_15_8,
   output logic [DATA_W-1:0] en_reg_pwm_7_0,
   output logic [DATA_W-1:0] en_reg_pwm_15_8,
   output logic [DATA_W-1:0] pwm_duty_cycle,
   output logic              update_pending,
   output logic              addr_err
);
   localparam int unsigned REG_CNT = 5;

   typedef enum logic {GRANT_A = 1'b0, GRANT_B = 1'b1} grant_t;

   grant_t            last_grant;
   logic              grant_a;
   logic              grant_b;
   logic              wr_en;
   logic              wr_ok;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              pending_nxt;
   logic [DATA_W-1:0] shadow      [REG_CNT];
   logic [DATA_W-1:0] shadow_nxt  [REG_CNT];
   logic [DATA_W-1:0] active      [REG_CNT];

   // Same-cycle grant; on contention the requester that did not win last time goes first.
   always_comb begin
      grant_a = 1'b0;
      grant_b = 1'b0;
      if (!rst) begin
         if (bus.a_valid && (!bus.b_valid || last_grant == GRANT_B)) begin
            grant_a = 1'b1;
         end else if (bus.b_valid) begin
            grant_b = 1'b1;
         end
      end
   end

   assign bus.a_ready = grant_a;
   assign bus.b_ready = grant_b;

   assign wr_en   = grant_a | grant_b;
   assign wr_addr = grant_a ? bus.a_addr : bus.b_addr;
   assign wr_data = grant_a ? bus.a_data : bus.b_data;
   assign wr_ok   = wr_en && (wr_addr <= ADDR_W'(REG_CNT - 1));

   // Shadow image including this cycle's write, so a coincident commit picks it up.
   always_comb begin
      for (int i = 0; i < int'(REG_CNT); i++) begin
         shadow_nxt[i] = shadow[i];
      end
      if (wr_ok) begin
         shadow_nxt[wr_addr[2:0]] = wr_data;
      end
      pending_nxt = update_pending | wr_ok;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant     <= GRANT_B;
         update_pending <= 1'b0;
         addr_err       <= 1'b0;
         for (int i = 0; i < int'(REG_CNT); i++) begin
            shadow[i] <= '0;
            active[i] <= '0;
         end
      end else begin
         if (grant_a) begin
            last_grant <= GRANT_A;
         end else if (grant_b) begin
            last_grant <= GRANT_B;
         end
         addr_err <= wr_en && !wr_ok;
         for (int i = 0; i < int'(REG_CNT); i++) begin
            shadow[i] <= shadow_nxt[i];
         end
         if (SYNC_UPDATE) begin
            if (period_start && pending_nxt) begin
               for (int i = 0; i < int'(REG_CNT); i++) begin
                  active[i] <= shadow_nxt[i];
               end
               update_pending <= 1'b0;
            end else begin
               update_pending <= pending_nxt;
            end
         end else begin
            for (int i = 0; i < int'(REG_CNT); i++) begin
               active[i] <= shadow_nxt[i];
            end
            update_pending <= 1'b0;
         end
      end
   end

   assign en_reg_out_7_0  = active[0];
   assign en_reg_out_15_8 = active[1];
   assign en_reg_pwm_7_0  = active[2];
   assign en_reg_pwm_15_8 = active[3];
   assign pwm_duty_cycle  = active[4];
endmodule

// File: tb/tb_pwm_cfg_arbiter.sv
// Directed bench for pwm_cfg_arbiter: synchronous-commit instance plus an immediate-update instance.
module tb_pwm_cfg_arbiter;
   logic clk = 1'b0;
   logic rst;
   logic period_start;

   logic [7:0] out_lo, out_hi, pwm_lo, pwm_hi, duty;
   logic       pending, addr_err;
   logic [7:0] s0_out_lo, s0_out_hi, s0_pwm_lo, s0_pwm_hi, s0_duty;
   logic       s0_pending, s0_addr_err;

   int checks = 0;
   int errors = 0;

   pwm_cfg_arbiter_if #(.ADDR_W(7), .DATA_W(8)) bus  ();
   pwm_cfg_arbiter_if #(.ADDR_W(7), .DATA_W(8)) bus0 ();

   pwm_cfg_arbiter #(.ADDR_W(7), .DATA_W(8), .SYNC_UPDATE(1'b1)) dut (
      .clk(clk), .rst(rst), .bus(bus.slave), .period_start(period_start),
      .en_reg_out_7_0(out_lo), .en_reg_out_15_8(out_hi), .en_reg_pwm_7_0(pwm_lo),
      .en_reg_pwm_15_8(pwm_hi), .pwm_duty_cycle(duty),
      .update_pending(pending), .addr_err(addr_err)
   );

   pwm_cfg_arbiter #(.ADDR_W(7), .DATA_W(8), .SYNC_UPDATE(1'b0)) dut0 (
      .clk(clk), .rst(rst), .bus(bus0.slave), .period_start(period_start),
      .en_reg_out_7_0(s0_out_lo), .en_reg_out_15_8(s0_out_hi), .en_reg_pwm_7_0(s0_pwm_lo),
      .en_reg_pwm_15_8(s0_pwm_hi), .pwm_duty_cycle(s0_duty),
      .update_pending(s0_pending), .addr_err(s0_addr_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1;
      period_start = 1'b0;
      bus.a_valid = 1'b0;  bus.a_addr = '0;  bus.a_data = '0;
      bus.b_valid = 1'b0;  bus.b_addr = '0;  bus.b_data = '0;
      bus0.a_valid = 1'b0; bus0.a_addr = '0; bus0.a_data = '0;
      bus0.b_valid = 1'b0; bus0.b_addr = '0; bus0.b_data = '0;
      @(negedge clk);
      @(negedge clk);
      check("rst_duty", duty, 8'h00);
      check("rst_out_lo", out_lo, 8'h00);
      check("rst_pending", {7'b0, pending}, 8'h00);
      check("rst_addr_err", {7'b0, addr_err}, 8'h00);
      rst = 1'b0;

      // 1: write held in shadow until period_start
      bus.a_valid = 1'b1; bus.a_addr = 7'h04; bus.a_data = 8'h80;
      #1 check("t1_a_ready", {7'b0, bus.a_ready}, 8'h01);
      check("t1_b_ready", {7'b0, bus.b_ready}, 8'h00);
      @(negedge clk);
      bus.a_valid = 1'b0;
      check("t1_duty_hold", duty, 8'h00);
      check("t1_pending", {7'b0, pending}, 8'h01);
      period_start = 1'b1;
      @(negedge clk);
      period_start = 1'b0;
      check("t1_duty_commit", duty, 8'h80);
      check("t1_pending_clr", {7'b0, pending}, 8'h00);

      // 2: fresh reset so A wins first contention, then strict alternation
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      bus.a_addr = 7'h00; bus.a_data = 8'h11;
      bus.b_addr = 7'h01; bus.b_data = 8'h22;
      for (int i = 0; i < 4; i++) begin
         bus.a_valid = 1'b1; bus.b_valid = 1'b1;
         #1 check("t2_a_ready", {7'b0, bus.a_ready}, (i % 2 == 0) ? 8'h01 : 8'h00);
         check("t2_b_ready", {7'b0, bus.b_ready}, (i % 2 == 1) ? 8'h01 : 8'h00);
         @(negedge clk);
      end
      bus.a_valid = 1'b0; bus.b_valid = 1'b0;
      check("t2_pending", {7'b0, pending}, 8'h01);
      check("t2_out_lo_hold", out_lo, 8'h00);
      period_start = 1'b1;
      @(negedge clk);
      period_start = 1'b0;
      check("t2_out_lo", out_lo, 8'h11);
      check("t2_out_hi", out_hi, 8'h22);
      check("t2_duty_lost", duty, 8'h00);

      // 3: out-of-range address accepted, flagged, no state change
      bus.b_valid = 1'b1; bus.b_addr = 7'h07; bus.b_data = 8'hFF;
      #1 check("t3_b_ready", {7'b0, bus.b_ready}, 8'h01);
      check("t3_err_early", {7'b0, addr_err}, 8'h00);
      @(negedge clk);
      bus.b_valid = 1'b0;
      check("t3_addr_err", {7'b0, addr_err}, 8'h01);
      check("t3_pending", {7'b0, pending}, 8'h00);
      check("t3_out_hi", out_hi, 8'h22);
      @(negedge clk);
      check("t3_err_clr", {7'b0, addr_err}, 8'h00);

      // 4: write coincident with period_start merges into the commit
      bus.a_valid = 1'b1; bus.a_addr = 7'h02; bus.a_data = 8'h0F;
      period_start = 1'b1;
      @(negedge clk);
      bus.a_valid = 1'b0; period_start = 1'b0;
      check("t4_pwm_lo", pwm_lo, 8'h0F);
      check("t4_pending", {7'b0, pending}, 8'h00);
      check("t4_out_lo", out_lo, 8'h11);

      // 5: reset discards pending write and blocks ready
      bus.a_valid = 1'b1; bus.a_addr = 7'h04; bus.a_data = 8'h33;
      @(negedge clk);
      check("t5_pending", {7'b0, pending}, 8'h01);
      rst = 1'b1; bus.a_addr = 7'h00; bus.a_data = 8'h55;
      #1 check("t5_a_ready_rst", {7'b0, bus.a_ready}, 8'h00);
      @(negedge clk);
      rst = 1'b0; bus.a_valid = 1'b0;
      check("t5_out_lo", out_lo, 8'h00);
      check("t5_out_hi", out_hi, 8'h00);
      check("t5_pwm_lo", pwm_lo, 8'h00);
      check("t5_pending_clr", {7'b0, pending}, 8'h00);
      period_start = 1'b1;
      @(negedge clk);
      period_start = 1'b0;
      check("t5_duty", duty, 8'h00);
      check("t5_out_lo_post", out_lo, 8'h00);

      // 6: immediate-update instance
      bus0.a_valid = 1'b1; bus0.a_addr = 7'h03; bus0.a_data = 8'hA5;
      #1 check("t6_a_ready", {7'b0, bus0.a_ready}, 8'h01);
      check("t6_pre", s0_pwm_hi, 8'h00);
      @(negedge clk);
      bus0.a_valid = 1'b0;
      check("t6_pwm_hi", s0_pwm_hi, 8'hA5);
      check("t6_pending", {7'b0, s0_pending}, 8'h00);
      check("t6_sync_hold", pwm_hi, 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
